bram_rd_streamer: RTL and testbench
===================================

BRAM_RD_STREAMER -- requirements
Module: bram_rd_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 72, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2048, number of RAM entries; AW = clogb2(DEPTH-1).
REQ-003 SHALL have parameter RD_LATENCY, default 2, RAM read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; minimum value is RD_LATENCY+2.
REQ-005 clk  in  1  single clock for all logic; RAM port shares it.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a transfer; ignored while busy=1.
REQ-008 base_addr  in  AW  first RAM address, sampled when start is accepted.
REQ-009 length  in  AW+1  number of words to read, sampled when start is accepted.
REQ-010 busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
REQ-011 done  out  1  one-cycle pulse after the last word has been accepted on the stream.
REQ-012 bram_addr  out  AW  RAM port address.
REQ-013 bram_en  out  1  RAM port enable.
REQ-014 bram_we  out  1  RAM write enable; constant 0.
REQ-015 bram_oreg_en  out  1  RAM output-register enable; bram_en delayed by 1 cycle, and 0 when RD_LATENCY=1.
REQ-016 bram_rst  out  1  RAM output-register reset; constant 0.
REQ-017 bram_dout  in  WIDTH  RAM read data.
REQ-018 m_data / m_valid / m_last  out  WIDTH/1/1  stream output; m_last marks the final word.
REQ-019 m_ready  in  1  stream backpressure.
REQ-020 stall_cycles  out  32  backpressure cycle counter (see Configuration).

Function
REQ-021 FSM SHALL have three states:
- IDLE: on start, go to RUN.
- RUN: when all reads are issued, go to DRAIN.
- DRAIN: when the FIFO is empty and nothing is in flight, assert done and go to IDLE.
REQ-022 start in IDLE with length=0 SHALL pulse done on the next cycle, issue no reads, and stay in IDLE.
REQ-023 A read SHALL be issued (bram_en=1, bram_we=0) only in RUN, only while words remain, and only when fifo_count + inflight < FIFO_DEPTH; pops in the same cycle are not credited.
REQ-024 Issued addresses SHALL be base_addr, +1, ...; after DEPTH-1 the address wraps to 0, by compare, with no power-of-two assumption.
REQ-025 A valid-tracking shift register of length RD_LATENCY SHALL capture bram_dout into the FIFO exactly RD_LATENCY cycles after each issue; each entry carries its last flag.
REQ-026 The FIFO SHALL be first-word-fall-through: m_valid = not empty; a pop happens on m_valid & m_ready.
REQ-027 m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 A simultaneous push and pop on a full or empty FIFO SHALL keep the count unchanged and lose no data.
REQ-029 With m_ready held at 1, the block SHALL sustain one word per cycle after the initial latency.
REQ-030 done SHALL be asserted in the cycle after the pop of the m_last word.

Reset
REQ-031 On rst, all outputs SHALL reset to 0, the FSM to IDLE, and the FIFO, inflight pipe, and counters SHALL be cleared immediately; a transfer in progress is abandoned with no done.
REQ-032 After rst is deasserted, the first start SHALL be accepted normally.

Configuration
REQ-033 The macro BRAM_RD_STREAMER_STALL_CNT_EN SHALL control the stall counter.
- Defined: stall_cycles increments by 1 (saturating) on every cycle with m_valid=1 & m_ready=0, and clears on accepted start and on rst.
- Undefined: stall_cycles is a constant 0 and no counter logic is built.

Verification
REQ-034 base_addr=0x010, length=8, m_ready=1 -> m_data = RAM[0x010..0x017] on 8 consecutive valid cycles, m_last on the 8th, done on the next cycle.
REQ-035 base_addr=DEPTH-2, length=4 -> addresses DEPTH-2, DEPTH-1, 0, 1 are issued in order.
REQ-036 length=16 with m_ready toggling 1,0,0,1,... -> no word lost or duplicated, and fifo_count + inflight never exceeds FIFO_DEPTH; with STALL_CNT_EN, stall_cycles equals the counted valid&!ready cycles.
REQ-037 length=0 -> done one cycle after start, bram_en never asserted.
REQ-038 rst asserted mid-transfer (after 3 of 10 words) -> m_valid, bram_en, and busy are 0 immediately; a new start with length=2 completes correctly.
REQ-039 start pulsed while busy -> ignored, and the current transfer's word count is unchanged.

Source files
------------

// File: rtl/bram_rd_streamer.sv
// Streams a contiguous (wrapping) range of BRAM words out through a FWFT buffer with credit-based read issue.
// Optional stall counter: define BRAM_RD_STREAMER_STALL_CNT_EN.
module bram_rd_streamer #(
   parameter int WIDTH      = 72,
   parameter int DEPTH      = 2048,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   input  logic [AW:0]       length,
   output logic              busy,
   output logic              done,
   output logic [AW-1:0]     bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic              bram_oreg_en,
   output logic              bram_rst,
   input  logic [WIDTH-1:0]  bram_dout,
   output logic [WIDTH-1:0]  m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic [31:0]       stall_cycles
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = CW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
   localparam logic [AW:0]   ONE_LEFT  = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q;
   logic [AW:0]       remain_q;
   logic              zdone_q;
   logic              accept;
   logic              issue;
   logic              drain_done;
   logic              vld_p0, lst_p0;
   logic              vld_cap, lst_cap;
   logic [1:0]        inflight;
   logic [OW-1:0]     occ;
   logic              push, pop;
   logic [CW-1:0]     fifo_count;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [WIDTH:0]    mem [FIFO_DEPTH];
   logic [WIDTH:0]    rd_word;

   assign accept = start && (state_q == IDLE);
   // Occupancy includes words still in the RAM pipe so the buffer can never overflow.
   assign occ    = OW'(fifo_count) + OW'(inflight);

   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      drain_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (length != '0)) state_d = RUN;
         end
         RUN: begin
            if ((remain_q != '0) && (occ < OW'(FIFO_DEPTH))) begin
               issue = 1'b1;
               if (remain_q == ONE_LEFT) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((fifo_count == '0) && (inflight == 2'd0)) begin
               drain_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         zdone_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         zdone_q <= accept && (length == '0);
         if (accept) begin
            addr_q   <= base_addr;
            remain_q <= length;
         end else if (issue) begin
            addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
         end
      end
   end

   // Stage p0: one cycle after issue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         lst_p0 <= 1'b0;
      end else begin
         vld_p0 <= issue;
         lst_p0 <= issue && (remain_q == ONE_LEFT);
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic vld_p1, lst_p1;
         // Stage p1: RAM output register holds the word
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_p1 <= 1'b0;
               lst_p1 <= 1'b0;
            end else begin
               vld_p1 <= vld_p0;
               lst_p1 <= lst_p0;
            end
         end
         assign vld_cap      = vld_p1;
         assign lst_cap      = lst_p1;
         assign inflight     = {1'b0, vld_p0} + {1'b0, vld_p1};
         assign bram_oreg_en = vld_p0;
      end else begin : g_lat1
         assign vld_cap      = vld_p0;
         assign lst_cap      = lst_p0;
         assign inflight     = {1'b0, vld_p0};
         assign bram_oreg_en = 1'b0;
      end
   endgenerate

   assign push = vld_cap;
   assign pop  = m_valid && m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {lst_cap, bram_dout};
   end

   assign rd_word      = mem[rd_ptr];
   assign m_valid      = (fifo_count != '0);
   assign m_data       = m_valid ? rd_word[WIDTH-1:0] : '0;
   assign m_last       = m_valid && rd_word[WIDTH];
   assign busy         = (state_q != IDLE);
   assign done         = zdone_q || drain_done;
   assign bram_addr    = addr_q;
   assign bram_en      = issue;
   assign bram_we      = 1'b0;
   assign bram_rst     = 1'b0;

`ifdef BRAM_RD_STREAMER_STALL_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 1'b1;
      end
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed bench for bram_rd_streamer with a 2-cycle BRAM model (enable + output register).
module tb_bram_rd_streamer;

   localparam int WIDTH = 72;
   localparam int DEPTH = 2048;
   localparam int AW    = 11;
   localparam int FD    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [AW-1:0]     base_addr = '0;
   logic [AW:0]       length = '0;
   logic              busy, done;
   logic [AW-1:0]     bram_addr;
   logic              bram_en, bram_we, bram_oreg_en, bram_rst;
   logic [WIDTH-1:0]  bram_dout;
   logic [WIDTH-1:0]  m_data;
   logic              m_valid, m_last;
   logic              m_ready = 1'b0;
   logic [31:0]       stall_cycles;

   int tests = 0;
   int fails = 0;

   logic [WIDTH-1:0]  ram_s1;
   logic [AW-1:0]     addr_log [$];

   bram_rd_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_oreg_en(bram_oreg_en), .bram_rst(bram_rst), .bram_dout(bram_dout),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ram_word(input logic [AW-1:0] a);
      return {8'h5A, 21'h0, a, 21'h1ABCD, a};
   endfunction

   function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
      return AW'((int'(base) + i) % DEPTH);
   endfunction

   always @(posedge clk) begin
      if (bram_en) begin
         ram_s1 <= ram_word(bram_addr);
         addr_log.push_back(bram_addr);
      end
      if (bram_oreg_en) bram_dout <= ram_s1;
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // rmode 0: always ready; 1: ready pattern 1,0,0 repeating. busy_at: cycle to pulse a stray start.
   task automatic xfer(input string nm, input logic [AW-1:0] base, input int len,
                       input int rmode, input int busy_at);
      int popped = 0, data_err = 0, last_err = 0, hold_err = 0, aerr = 0;
      int stalls = 0, max_occ = 0, occ_now;
      int first_pop = -1, last_pop = -1, done_cyc = -1;
      bit got_done = 0, hold_prev = 0, rdy;
      logic [WIDTH-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      int exp_stall;
      addr_log.delete();
      @(negedge clk);
      start = 1'b1; base_addr = base; length = 12'(len);
      @(negedge clk);
      start = 1'b0;
      chk({nm, " busy_after_start"}, 72'(busy), 72'd1);
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
         @(negedge clk);
         if (hold_prev && ((m_data !== prev_data) || (m_last !== prev_last))) hold_err++;
         if (done) begin got_done = 1; done_cyc = cyc; end
         if (cyc == busy_at) begin start = 1'b1; base_addr = '0; length = 12'd5; end
         else start = 1'b0;
         rdy = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
         m_ready = rdy;
         occ_now = addr_log.size() - popped;
         if (occ_now > max_occ) max_occ = occ_now;
         if (m_valid && rdy) begin
            if (m_data !== ram_word(exp_addr(base, popped))) data_err++;
            if (m_last !== (popped == len - 1)) last_err++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            popped++;
         end
         if (m_valid && !rdy) stalls++;
         hold_prev = m_valid && !rdy;
         prev_data = m_data;
         prev_last = m_last;
      end
      start = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < addr_log.size(); i++)
         if (addr_log[i] !== exp_addr(base, i)) aerr++;
      chk({nm, " done_seen"}, 72'(got_done), 72'd1);
      chk({nm, " words_popped"}, 72'(popped), 72'(len));
      chk({nm, " data_errors"}, 72'(data_err), 72'd0);
      chk({nm, " last_errors"}, 72'(last_err), 72'd0);
      chk({nm, " done_after_last_pop"}, 72'(done_cyc), 72'(last_pop + 1));
      chk({nm, " hold_errors"}, 72'(hold_err), 72'd0);
      chk({nm, " occupancy_within_fifo"}, 72'(max_occ <= FD), 72'd1);
      chk({nm, " reads_issued"}, 72'(addr_log.size()), 72'(len));
      chk({nm, " address_errors"}, 72'(aerr), 72'd0);
      if (rmode == 0) chk({nm, " one_word_per_cycle"}, 72'(last_pop - first_pop), 72'(len - 1));
`ifdef BRAM_RD_STREAMER_STALL_CNT_EN
      exp_stall = stalls;
`else
      exp_stall = 0;
`endif
      chk({nm, " stall_cycles"}, 72'(stall_cycles), 72'(exp_stall));
      @(negedge clk);
      chk({nm, " idle_busy"}, 72'(busy), 72'd0);
      chk({nm, " idle_done"}, 72'(done), 72'd0);
   endtask

   initial begin
      int n;
      @(negedge clk);
      chk("rst busy", 72'(busy), 72'd0);
      chk("rst done", 72'(done), 72'd0);
      chk("rst m_valid", 72'(m_valid), 72'd0);
      chk("rst m_last", 72'(m_last), 72'd0);
      chk("rst m_data", 72'(m_data), 72'd0);
      chk("rst bram_en", 72'(bram_en), 72'd0);
      chk("rst bram_oreg_en", 72'(bram_oreg_en), 72'd0);
      chk("rst bram_addr", 72'(bram_addr), 72'd0);
      chk("rst stall", 72'(stall_cycles), 72'd0);
      chk("bram_we", 72'(bram_we), 72'd0);
      chk("bram_rst", 72'(bram_rst), 72'd0);
      rst = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);

      xfer("basic8", 11'h010, 8, 0, -1);
      xfer("wrap4", 11'(DEPTH - 2), 4, 0, -1);
      xfer("bp16", 11'h040, 16, 1, -1);

      addr_log.delete();
      @(negedge clk);
      start = 1'b1; base_addr = 11'h005; length = 12'd0;
      @(negedge clk);
      start = 1'b0;
      chk("zero done", 72'(done), 72'd1);
      chk("zero busy", 72'(busy), 72'd0);
      @(negedge clk);
      chk("zero done_cleared", 72'(done), 72'd0);
      chk("zero no_reads", 72'(addr_log.size()), 72'd0);

      xfer("busystart16", 11'h080, 16, 0, 5);

      addr_log.delete();
      @(negedge clk);
      start = 1'b1; base_addr = 11'h100; length = 12'd10;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 100 && n < 3; c++) begin
         @(negedge clk);
         if (m_valid) n++;
      end
      chk("midrst pops_before_reset", 72'(n), 72'd3);
      @(negedge clk);
      chk("midrst valid_before_reset", 72'(m_valid), 72'd1);
      rst = 1'b1;
      #1;
      chk("midrst m_valid", 72'(m_valid), 72'd0);
      chk("midrst bram_en", 72'(bram_en), 72'd0);
      chk("midrst busy", 72'(busy), 72'd0);
      chk("midrst done", 72'(done), 72'd0);
      @(negedge clk);
      @(negedge clk);
      chk("midrst done_held", 72'(done), 72'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst no_done_after", 72'(done), 72'd0);

      xfer("after_rst2", 11'h200, 2, 0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
